// File: rtl/mms_rx_pkg.sv
// rtl/mms_rx_pkg.sv - MAC Merge receive constants, SMD codes and state type
package mms_rx_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SMD_E         = 8'hD5;
    localparam logic [7:0] SMD_V         = 8'h07;
    localparam logic [7:0] SMD_R         = 8'h19;

    // Index i of each table is frame number / fragment count i.
    localparam logic [0:3][7:0] SMD_S    = {8'hE6, 8'h4C, 8'h7F, 8'hB3};
    localparam logic [0:3][7:0] SMD_C    = {8'h61, 8'h52, 8'h2A, 8'h9E};
    localparam logic [0:3][7:0] FRAG_CNT = {8'hE6, 8'h4C, 8'h7F, 8'hB3};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_FRAG_COUNT,
        ST_DATA,
        ST_DISCARD
    } rx_state_t;

    // Returns {hit, index} of byte b within a four-entry code table.
    function automatic logic [2:0] code_lookup(input logic [7:0] b,
                                               input logic [0:3][7:0] tbl);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (b == tbl[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mms_rx_nibble_asm.sv
// rtl/mms_rx_nibble_asm.sv - MII nibble to byte assembler with frame-end detect
module mms_rx_nibble_asm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rxd,
    input  logic       rx_dv,
    input  logic       rx_er,
    output logic       dv_reg,
    output logic       byte_ready,
    output logic [7:0] byte_data,
    output logic       byte_er,
    output logic       phase,
    output logic       frame_end
);

    logic [3:0] lo_nib;
    logic       lo_er;

    // Pair low/high nibbles into a byte; rx_er on either nibble marks the byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_reg     <= 1'b0;
            byte_ready <= 1'b0;
            byte_data  <= 8'h00;
            byte_er    <= 1'b0;
            phase      <= 1'b0;
            frame_end  <= 1'b0;
            lo_nib     <= 4'h0;
            lo_er      <= 1'b0;
        end else begin
            dv_reg     <= rx_dv;
            byte_ready <= 1'b0;
            frame_end  <= dv_reg & ~rx_dv;
            if (rx_dv) begin
                if (!phase) begin
                    lo_nib <= rxd;
                    lo_er  <= rx_er;
                    phase  <= 1'b1;
                end else begin
                    byte_data  <= {rxd, lo_nib};
                    byte_er    <= lo_er | rx_er;
                    byte_ready <= 1'b1;
                    phase      <= 1'b0;
                end
            end else begin
                // A dangling low nibble is dropped here.
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mms_rx_smd_classifier.sv
// rtl/mms_rx_smd_classifier.sv - SMD/preamble classifier; optional MMS_FRAG_SEQ_CHECK_EN
module mms_rx_smd_classifier
    import mms_rx_pkg::*;
#(
    parameter int MAX_PREAMBLE = 15,
    parameter int FRAG_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        rxd,
    input  logic              rx_dv,
    input  logic              rx_er,
    output logic              r_rx_dv,
    output logic              r_byte_ready,
    output logic [7:0]        r_rx_data,
    output logic              pream,
    output logic              e,
    output logic              v,
    output logic              r,
    output logic              s,
    output logic              c,
    output logic              err,
    output logic [FRAG_W-1:0] smd_frame,
    output logic              frag_valid,
    output logic [FRAG_W-1:0] frag_cnt,
    output logic              frame_end,
    output logic              odd_nibble
);

    localparam int CNT_W = $clog2(MAX_PREAMBLE + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PREAMBLE + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_PREAMBLE);

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] pre_cnt, pre_cnt_nxt;
    logic             byte_er;
    logic             phase;
    logic [2:0]       s_lu, c_lu, f_lu;

`ifdef MMS_FRAG_SEQ_CHECK_EN
    logic [FRAG_W-1:0] exp_frag, exp_frag_nxt;
    logic [FRAG_W-1:0] s_last, s_last_nxt;
    logic [FRAG_W-1:0] c_frame, c_frame_nxt;
`endif

    mms_rx_nibble_asm u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .dv_reg     (r_rx_dv),
        .byte_ready (r_byte_ready),
        .byte_data  (r_rx_data),
        .byte_er    (byte_er),
        .phase      (phase),
        .frame_end  (frame_end)
    );

    assign s_lu = code_lookup(r_rx_data, SMD_S);
    assign c_lu = code_lookup(r_rx_data, SMD_C);
    assign f_lu = code_lookup(r_rx_data, FRAG_CNT);

    // Odd-nibble flag is captured on the same edge that raises frame_end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd_nibble <= 1'b0;
        end else begin
            odd_nibble <= r_rx_dv & ~rx_dv & phase;
        end
    end

    // State, preamble counter and fragment-sequence registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pre_cnt <= '0;
`ifdef MMS_FRAG_SEQ_CHECK_EN
            exp_frag <= '0;
            s_last   <= '0;
            c_frame  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_cnt_nxt;
`ifdef MMS_FRAG_SEQ_CHECK_EN
            exp_frag <= exp_frag_nxt;
            s_last   <= s_last_nxt;
            c_frame  <= c_frame_nxt;
`endif
        end
    end

    // Classify each strobed byte by state; flags only ever rise with r_byte_ready.
    always_comb begin
        state_nxt   = state;
        pre_cnt_nxt = pre_cnt;
        pream       = 1'b0;
        e           = 1'b0;
        v           = 1'b0;
        r           = 1'b0;
        s           = 1'b0;
        c           = 1'b0;
        err         = 1'b0;
        smd_frame   = '0;
        frag_valid  = 1'b0;
        frag_cnt    = '0;
`ifdef MMS_FRAG_SEQ_CHECK_EN
        exp_frag_nxt = exp_frag;
        s_last_nxt   = s_last;
        c_frame_nxt  = c_frame;
`endif
        case (state)
            ST_IDLE: begin
                pre_cnt_nxt = '0;
                if (r_rx_dv) begin
                    state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (r_byte_ready) begin
                    if (byte_er) begin
                        err       = 1'b1;
                        state_nxt = ST_DISCARD;
                    end else if (r_rx_data == PREAMBLE_BYTE) begin
                        if (pre_cnt != CNT_SAT) begin
                            pre_cnt_nxt = pre_cnt + CNT_W'(1);
                        end
                        if (pre_cnt >= CNT_LIM) begin
                            err       = 1'b1;
                            state_nxt = ST_DISCARD;
                        end else begin
                            pream = 1'b1;
                        end
                    end else if (r_rx_data == SMD_E) begin
                        e         = 1'b1;
                        state_nxt = ST_DATA;
                    end else if (r_rx_data == SMD_V) begin
                        v         = 1'b1;
                        state_nxt = ST_DATA;
                    end else if (r_rx_data == SMD_R) begin
                        r         = 1'b1;
                        state_nxt = ST_DATA;
                    end else if (s_lu[2]) begin
                        s         = 1'b1;
                        smd_frame = FRAG_W'(s_lu[1:0]);
                        state_nxt = ST_DATA;
`ifdef MMS_FRAG_SEQ_CHECK_EN
                        exp_frag_nxt = '0;
                        s_last_nxt   = FRAG_W'(s_lu[1:0]);
`endif
                    end else if (c_lu[2]) begin
                        c         = 1'b1;
                        smd_frame = FRAG_W'(c_lu[1:0]);
                        state_nxt = ST_FRAG_COUNT;
`ifdef MMS_FRAG_SEQ_CHECK_EN
                        c_frame_nxt = FRAG_W'(c_lu[1:0]);
`endif
                    end else begin
                        err       = 1'b1;
                        state_nxt = ST_DISCARD;
                    end
                end
            end
            ST_FRAG_COUNT: begin
                if (r_byte_ready) begin
                    if (byte_er) begin
                        err       = 1'b1;
                        state_nxt = ST_DISCARD;
                    end else if (f_lu[2]) begin
                        frag_valid = 1'b1;
                        frag_cnt   = FRAG_W'(f_lu[1:0]);
`ifdef MMS_FRAG_SEQ_CHECK_EN
                        // Out-of-order fragment or a C frame not matching the open S frame.
                        if ((frag_cnt != exp_frag) || (c_frame != s_last)) begin
                            err       = 1'b1;
                            state_nxt = ST_DISCARD;
                        end else begin
                            exp_frag_nxt = exp_frag + FRAG_W'(1);
                            state_nxt    = ST_DATA;
                        end
`else
                        state_nxt = ST_DATA;
`endif
                    end else begin
                        err       = 1'b1;
                        state_nxt = ST_DISCARD;
                    end
                end
            end
            ST_DATA, ST_DISCARD: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (frame_end) begin
            state_nxt = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_mms_rx_smd_classifier.sv
// tb/tb_mms_rx_smd_classifier.sv - directed self-checking bench for mms_rx_smd_classifier
module tb_mms_rx_smd_classifier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rxd = 4'h0;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic       r_rx_dv, r_byte_ready;
    logic [7:0] r_rx_data;
    logic       pream, e, v, r, s, c, err;
    logic [1:0] smd_frame, frag_cnt;
    logic       frag_valid, frame_end, odd_nibble;

    int checks = 0;
    int failures = 0;

`ifdef MMS_FRAG_SEQ_CHECK_EN
    localparam int SEQ_ERR_CLS = 7;
`else
    localparam int SEQ_ERR_CLS = 0;
`endif

    mms_rx_smd_classifier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .r_rx_dv      (r_rx_dv),
        .r_byte_ready (r_byte_ready),
        .r_rx_data    (r_rx_data),
        .pream        (pream),
        .e            (e),
        .v            (v),
        .r            (r),
        .s            (s),
        .c            (c),
        .err          (err),
        .smd_frame    (smd_frame),
        .frag_valid   (frag_valid),
        .frag_cnt     (frag_cnt),
        .frame_end    (frame_end),
        .odd_nibble   (odd_nibble)
    );

    always #5 clk = ~clk;

    // Expected per-byte records.
    logic [7:0] xb[$];
    int         xc[$];
    int         xsf[$];
    int         xfv[$];
    int         xfc[$];
    logic       xer[$];

    // Observed per-byte records.
    int lb[$];
    int lc[$];
    int lsf[$];
    int lfv[$];
    int lfc[$];
    int lones[$];
    int fe_cnt;
    int fe_odd;
    int stray;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({r_rx_dv, r_byte_ready, r_rx_data, pream, e, v, r, s, c, err,
                     smd_frame, frag_valid, frag_cnt, frame_end, odd_nibble});
    endfunction

    // Observe outputs 1ns after each active edge.
    always @(posedge clk) begin
        #1;
        if (r_byte_ready) begin
            lb.push_back(int'(r_rx_data));
            lc.push_back(pream ? 1 : e ? 2 : v ? 3 : r ? 4 : s ? 5 : c ? 6 : err ? 7 : 0);
            lsf.push_back(int'(smd_frame));
            lfv.push_back(int'(frag_valid));
            lfc.push_back(int'(frag_cnt));
            lones.push_back($countones({pream, e, v, r, s, c, err}));
        end else if ({pream, e, v, r, s, c, err, frag_valid} != 8'h00) begin
            stray++;
        end
        if (frame_end) begin
            fe_cnt++;
            fe_odd = int'(odd_nibble);
        end else if (odd_nibble) begin
            stray++;
        end
    end

    task automatic new_frame();
        xb.delete(); xc.delete(); xsf.delete(); xfv.delete(); xfc.delete(); xer.delete();
    endtask

    task automatic add(input logic [7:0] b, input int cls, input int sf = 0,
                       input int fv = 0, input int fc = 0, input logic er = 1'b0);
        xb.push_back(b); xc.push_back(cls); xsf.push_back(sf);
        xfv.push_back(fv); xfc.push_back(fc); xer.push_back(er);
    endtask

    task automatic add_pream(input int n);
        for (int i = 0; i < n; i++) add(8'h55, 1);
    endtask

    task automatic nib(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk);
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
    endtask

    task automatic clear_log();
        lb.delete(); lc.delete(); lsf.delete(); lfv.delete(); lfc.delete(); lones.delete();
        fe_cnt = 0;
        fe_odd = 0;
        stray  = 0;
    endtask

    task automatic run_frame(input bit odd, input int gap);
        logic [7:0] b;
        clear_log();
        for (int i = 0; i < xb.size(); i++) begin
            b = xb[i];
            nib(1'b1, b[3:0], 1'b0);
            nib(1'b1, b[7:4], xer[i]);
        end
        if (odd) nib(1'b1, 4'hA, 1'b0);
        nib(1'b0, 4'h0, 1'b0);
        repeat (gap) @(posedge clk);
        #2;
    endtask

    task automatic verify(input string tag, input int exp_fe, input int exp_odd);
        int n;
        check_eq({tag, "_nbytes"}, lb.size(), xb.size());
        n = (lb.size() < xb.size()) ? lb.size() : xb.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_b%0d_data", tag, i), lb[i], int'(xb[i]));
            check_eq($sformatf("%s_b%0d_cls", tag, i), lc[i], xc[i]);
            check_eq($sformatf("%s_b%0d_nflags", tag, i), lones[i], (xc[i] != 0) ? 1 : 0);
            check_eq($sformatf("%s_b%0d_fv", tag, i), lfv[i], xfv[i]);
            if (xc[i] == 5 || xc[i] == 6)
                check_eq($sformatf("%s_b%0d_sf", tag, i), lsf[i], xsf[i]);
            if (xfv[i] != 0)
                check_eq($sformatf("%s_b%0d_fc", tag, i), lfc[i], xfc[i]);
        end
        check_eq({tag, "_frame_end"}, fe_cnt, exp_fe);
        check_eq({tag, "_odd"}, fe_odd, exp_odd);
        check_eq({tag, "_stray"}, stray, 0);
    endtask

    initial begin
        fe_cnt = 0;
        fe_odd = 0;
        stray  = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_vec(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 7 preamble, SMD-E, 4 data bytes, even end
        new_frame(); add_pream(7); add(8'hD5, 2);
        for (int i = 1; i <= 4; i++) add(8'(i), 0);
        run_frame(1'b0, 4); verify("express", 1, 0);

        // SMD-C0 followed by frag count 0
        new_frame(); add_pream(6); add(8'h61, 6, 0); add(8'hE6, 0, 0, 1, 0);
        add(8'hA5, 0); add(8'h3C, 0);
        run_frame(1'b0, 4); verify("smdc0", 1, 0);

        // SMD-V followed by 60 data bytes, including SMD-like values
        new_frame(); add_pream(6); add(8'h07, 3);
        for (int i = 0; i < 60; i++) add(8'((i * 37 + 5) & 255), 0);
        run_frame(1'b0, 4); verify("verify", 1, 0);

        // illegal byte after preamble
        new_frame(); add_pream(3); add(8'h12, 7); add(8'h55, 0); add(8'hD5, 0);
        run_frame(1'b0, 4); verify("badsmd", 1, 0);

        // 16th consecutive preamble byte is an error
        new_frame(); add_pream(15); add(8'h55, 7); add(8'hD5, 0);
        run_frame(1'b0, 4); verify("longpre", 1, 0);

        // frame ends on a half byte
        new_frame(); add_pream(2); add(8'hD5, 2);
        run_frame(1'b1, 4); verify("oddend", 1, 1);

        // rx_er on the high nibble of a preamble byte
        new_frame(); add_pream(2); add(8'h55, 7, 0, 0, 0, 1'b1); add(8'hD5, 0);
        run_frame(1'b0, 4); verify("rxer", 1, 0);

        // SMD-C3 followed by an invalid fragment-count byte
        new_frame(); add_pream(2); add(8'h9E, 6, 3); add(8'h12, 7); add(8'h01, 0);
        run_frame(1'b0, 4); verify("badfrag", 1, 0);

        // one-cycle rx_dv gap: frame end then a fresh frame
        new_frame(); add_pream(2); add(8'h19, 4); add(8'hAA, 0);
        run_frame(1'b0, 1); verify("gap_a", 1, 0);
        new_frame(); add_pream(2); add(8'hB3, 5, 3); add(8'h11, 0);
        run_frame(1'b0, 4); verify("gap_b", 1, 0);

        // SMD-S1, then SMD-C1 carrying fragment 1 where 0 is next
        new_frame(); add_pream(2); add(8'h4C, 5, 1); add(8'h00, 0);
        run_frame(1'b0, 4); verify("seq_s", 1, 0);
        new_frame(); add_pream(2); add(8'h52, 6, 1); add(8'h4C, SEQ_ERR_CLS, 0, 1, 1);
        add(8'h33, 0);
        run_frame(1'b0, 4); verify("seq_c", 1, 0);

        // reset in the middle of the preamble
        clear_log();
        for (int i = 0; i < 3; i++) begin
            nib(1'b1, 4'h5, 1'b0);
            nib(1'b1, 4'h5, 1'b0);
        end
        @(posedge clk);
        #3;
        check_eq("rst_pre_strobe", int'(r_byte_ready), 1);
        check_eq("rst_pre_pream", int'(pream), 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outputs", out_vec(), 0);
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        new_frame(); add_pream(2); add(8'h19, 4); add(8'h5A, 0);
        run_frame(1'b0, 4); verify("after_rst", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
